// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: load/store types, FSM
// states, access sizes and byte-lane masks.
package dmem_pkg;

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LB  = 3'b001;
    localparam logic [2:0] LD_LBU = 3'b010;
    localparam logic [2:0] LD_LH  = 3'b011;
    localparam logic [2:0] LD_LHU = 3'b100;

    localparam logic [1:0] ST_SW = 2'b00;
    localparam logic [1:0] ST_SB = 2'b01;
    localparam logic [1:0] ST_SH = 2'b10;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_BUSY = 2'd1;
    localparam state_t S_RESP = 2'd2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    // Reserved encodings fall through to a full-word access.
    function automatic size_t access_size(input logic we, input logic [2:0] ld,
                                          input logic [1:0] st);
        size_t sz;
        sz = SZ_WORD;
        if (we) begin
            if (st == ST_SB)      sz = SZ_BYTE;
            else if (st == ST_SH) sz = SZ_HALF;
        end else begin
            if (ld == LD_LB || ld == LD_LBU)      sz = SZ_BYTE;
            else if (ld == LD_LH || ld == LD_LHU) sz = SZ_HALF;
        end
        return sz;
    endfunction

    function automatic logic [3:0] lane_mask(input size_t sz);
        logic [3:0] m;
        case (sz)
            SZ_BYTE: m = MASK_BYTE;
            SZ_HALF: m = MASK_HALF;
            default: m = MASK_WORD;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Synchronous single-port word array with per-byte write enables.
// Contents are intentionally not reset.
module dmem_bank #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Latency-programmable data-memory responder for a CPU MEM stage.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses instead of aligning them.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_load,
    input  logic [1:0]  req_store,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic          cap_we;
    logic [AW+1:0] cap_addr;
    logic [31:0]   cap_wdata;
    logic [2:0]    cap_load;
    logic [1:0]    cap_store;

    logic          accept;
    logic          enter_resp;
    logic          cur_we;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [2:0]    cur_load;
    logic [1:0]    cur_store;
    size_t         cur_size;
    logic [1:0]    eff_off;
    logic          trap;
    logic [3:0]    bank_be;
    logic [31:0]   bank_wdata;
    logic [31:0]   bank_rdata;
    logic [31:0]   shifted;
    logic [31:0]   ext;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign accept     = (state == S_IDLE) && req_valid;
    assign enter_resp = (accept && LATENCY == 1) || (state == S_BUSY && cnt == 4'd1);

    // With LATENCY=1 the bank is accessed on the accept edge, so use the live fields.
    always_comb begin
        if (state == S_IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr[AW+1:0];
            cur_wdata = req_wdata;
            cur_load  = req_load;
            cur_store = req_store;
        end else begin
            cur_we    = cap_we;
            cur_addr  = cap_addr;
            cur_wdata = cap_wdata;
            cur_load  = cap_load;
            cur_store = cap_store;
        end
    end

    assign cur_size = access_size(cur_we, cur_load, cur_store);

    always_comb begin
        eff_off = cur_addr[1:0];
        trap    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (cur_size == SZ_HALF) trap = cur_addr[0];
        else if (cur_size == SZ_WORD) trap = (cur_addr[1:0] != 2'b00);
`else
        if (cur_size == SZ_HALF) eff_off = {cur_addr[1], 1'b0};
        else if (cur_size == SZ_WORD) eff_off = 2'b00;
`endif
    end

    always_comb begin
        bank_be = lane_mask(cur_size) << eff_off;
        case (cur_size)
            SZ_BYTE: bank_wdata = {4{cur_wdata[7:0]}};
            SZ_HALF: bank_wdata = {2{cur_wdata[15:0]}};
            default: bank_wdata = cur_wdata;
        endcase
    end

    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_bank (
        .clk   (clk),
        .en    (enter_resp && !trap),
        .we    (cur_we),
        .be    (bank_be),
        .addr  (cur_addr[AW+1:2]),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // Captured fields stay put in RESP, so the offset and type recompute identically.
    always_comb begin
        shifted = bank_rdata >> {eff_off, 3'b000};
        case (cur_load)
            LD_LB:   ext = {{24{shifted[7]}}, shifted[7:0]};
            LD_LBU:  ext = {24'd0, shifted[7:0]};
            LD_LH:   ext = {{16{shifted[15]}}, shifted[15:0]};
            LD_LHU:  ext = {16'd0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = rsp_valid && trap;
    assign rsp_rdata = (rsp_valid && !cur_we && !trap) ? ext : 32'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= 32'd0;
            cap_load  <= 3'd0;
            cap_store <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr[AW+1:0];
                        cap_wdata <= req_wdata;
                        cap_load  <= req_load;
                        cap_store <= req_store;
                        if (LATENCY == 1) begin
                            state <= S_RESP;
                        end else begin
                            state <= S_BUSY;
                            cnt   <= LAT_LOAD;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed and randomized bench for data_mem_responder against a byte-array model.
module tb_data_mem_responder;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 256;
    localparam int BYTES   = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_load = 3'd0;
    logic [1:0]  req_store = 2'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [BYTES];

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_load(req_load), .req_store(req_store), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-level reference: sizes from the encodings, little-endian gather/scatter.
    task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] ld, input logic [1:0] st,
                         output logic [31:0] rd, output logic er);
        int nb, off, base;
        logic [31:0] v;
        if (we) nb = (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
        else    nb = (ld == 3'd1 || ld == 3'd2) ? 1 : (ld == 3'd3 || ld == 3'd4) ? 2 : 4;
        off  = int'(addr[1:0]);
        base = int'(addr[9:0]) - off;
        rd = 32'd0;
        er = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (off % nb != 0) begin
            er = 1'b1;
            return;
        end
`else
        off = off - (off % nb);
`endif
        if (we) begin
            for (int i = 0; i < nb; i++) mem[base + off + i] = wdata[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mem[base + off + i];
            if ((ld == 3'd1 || ld == 3'd3) && v[8*nb-1])
                for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
            rd = v;
        end
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] ld, input logic [1:0] st, input int hold,
                        output logic [31:0] rd);
        int edges;
        logic [31:0] exp_rd, first_rd;
        logic exp_er;
        model(we, addr, wdata, ld, st, exp_rd, exp_er);
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_load = ld; req_store = st;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_load = 3'($urandom); req_store = 2'($urandom);
        edges = 1;
        while (rsp_valid !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("latency", edges, LATENCY);
        rd = rsp_rdata;
        first_rd = rsp_rdata;
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", rsp_err, exp_er);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, first_rd);
            chk("hold_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("release_valid", rsp_valid, 0);
        chk("release_ready", req_ready, 1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] exp_misalign;
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        @(negedge clk); rst = 1'b1;

        for (int w = 0; w < 64; w++) xact(1'b1, 32'(w * 4), $urandom, 3'd0, 2'd0, 0, rd);

        xact(1'b1, 32'h10, 32'h8000FF7F, 3'd0, 2'd0, 0, rd);
        xact(1'b0, 32'h10, 32'd0, 3'd0, 2'd0, 0, rd); chk("lw10", rd, 32'h8000FF7F);
        xact(1'b0, 32'h10, 32'd0, 3'd1, 2'd0, 0, rd); chk("lb10", rd, 32'h0000007F);
        xact(1'b0, 32'h13, 32'd0, 3'd1, 2'd0, 0, rd); chk("lb13", rd, 32'hFFFFFF80);
        xact(1'b0, 32'h13, 32'd0, 3'd2, 2'd0, 0, rd); chk("lbu13", rd, 32'h00000080);
        xact(1'b0, 32'h12, 32'd0, 3'd3, 2'd0, 0, rd); chk("lh12", rd, 32'hFFFF8000);
        xact(1'b0, 32'h10, 32'd0, 3'd4, 2'd0, 0, rd); chk("lhu10", rd, 32'h0000FF7F);

        xact(1'b1, 32'h10, 32'h11223344, 3'd0, 2'd0, 0, rd);
        xact(1'b1, 32'h11, 32'h000000AB, 3'd0, 2'd1, 0, rd);
        xact(1'b0, 32'h10, 32'd0, 3'd0, 2'd0, 0, rd); chk("sb11", rd, 32'h1122AB44);
        xact(1'b1, 32'h12, 32'h0000BEEF, 3'd0, 2'd2, 0, rd);
        xact(1'b0, 32'h10, 32'd0, 3'd0, 2'd0, 5, rd); chk("sh12", rd, 32'hBEEFAB44);

        // Abort a store in BUSY with an asynchronous reset.
        xact(1'b1, 32'h20, 32'h11111111, 3'd0, 2'd0, 0, rd);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        req_load = 3'd0; req_store = 2'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("busy_ready", req_ready, 0);
        chk("busy_valid", rsp_valid, 0);
        rst = 1'b0; #1;
        chk("abort_ready", req_ready, 1);
        chk("abort_valid", rsp_valid, 0);
        chk("abort_rdata", rsp_rdata, 0);
        chk("abort_err", rsp_err, 0);
        @(posedge clk); @(negedge clk); rst = 1'b1;
        xact(1'b0, 32'h20, 32'd0, 3'd0, 2'd0, 0, rd); chk("abort_keep", rd, 32'h11111111);

        xact(1'b0, 32'h22, 32'd0, 3'd0, 2'd0, 0, rd);
`ifdef DMEM_MISALIGN_TRAP_EN
        exp_misalign = 32'd0;
`else
        exp_misalign = 32'h11111111;
`endif
        chk("lw22", rd, exp_misalign);

        xact(1'b1, 32'h400, 32'hCAFEF00D, 3'd0, 2'd0, 0, rd);
        xact(1'b0, 32'h000, 32'd0, 3'd0, 2'd0, 0, rd); chk("alias", rd, 32'hCAFEF00D);

        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0, 2'b00, 8'($urandom)};
            xact(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 2), rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
